// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: FSM encoding, reset
// oversampling value and the frame-abort timeout helper.
package uart_rx_ctrl_pkg;

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_APPLY    = 2'd3;

    localparam int PRESCALE_RST   = 8;
    localparam int FRAME_OVERHEAD = 3;   // start + parity + stop on top of the data bits
    localparam int IDLE_CNT_W     = 16;

    // Abort limit: twice the nominal frame length in oversampled clocks.
    function automatic logic [IDLE_CNT_W-1:0] timeout_limit(
        input logic [IDLE_CNT_W-1:0] prescale,
        input int                    data_width
    );
        timeout_limit = IDLE_CNT_W'(2 * int'(prescale) * (data_width + FRAME_OVERHEAD));
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Small synchronous FIFO buffering received bytes for the consumer port.
// Push while full is accepted only if a pop happens in the same cycle.
module rx_ctrl_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Head reads as zero when empty so the output is clean out of reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: between-frame config apply, line gating, frame
// tracking and a receive FIFO. Optional macro UART_RX_CTRL_ERR_CNT_EN adds frame_err_cnt.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_AW        = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cfg_wr,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    input  logic                      cfg_rx_en,
    input  logic                      RX_IN,
    output logic                      rx_line,
    output logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      PAR_EN,
    output logic                      PAR_TYP,
    input  logic [DATA_WIDTH-1:0]     rx_p_data,
    input  logic                      rx_data_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      ovr_clr,
    output logic                      overrun,
`ifdef UART_RX_CTRL_ERR_CNT_EN
    output logic [7:0]                frame_err_cnt,
`endif
    output logic                      cfg_pending,
    output logic                      busy
);

    logic [1:0]                state, next_state;
    logic [IDLE_CNT_W-1:0]     idle_cnt;
    logic [IDLE_CNT_W-1:0]     timeout_val;
    logic                      timeout_hit;
    logic                      apply_now;
    logic                      push_req;
    logic                      drop;
    logic [PRESCALE_WIDTH-1:0] pend_prescale;
    logic                      pend_par_en;
    logic                      pend_par_typ;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_AW:0]          fifo_count;

    assign timeout_val = timeout_limit(IDLE_CNT_W'(Prescale), DATA_WIDTH);
    assign timeout_hit = (idle_cnt == timeout_val);

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_DISABLED;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_DISABLED: if (cfg_rx_en) next_state = ST_IDLE;
            ST_IDLE: begin
                if (!cfg_rx_en)       next_state = ST_DISABLED;
                else if (!RX_IN)      next_state = ST_ACTIVE;
                else if (cfg_pending) next_state = ST_APPLY;
            end
            ST_ACTIVE: begin
                if (rx_data_valid)   next_state = ST_IDLE;
                else if (timeout_hit) next_state = ST_IDLE;
                else if (!cfg_rx_en)  next_state = ST_DISABLED;
            end
            ST_APPLY:    next_state = ST_IDLE;
            default:     next_state = ST_DISABLED;
        endcase
    end

    always_comb begin
        busy      = (state == ST_ACTIVE);
        // No frame can be in flight while disabled, so staged config lands immediately.
        apply_now = cfg_pending && ((state == ST_APPLY) || (state == ST_DISABLED));
        rx_line   = cfg_rx_en ? RX_IN : 1'b1;
        push_req  = rx_data_valid && (state != ST_DISABLED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (state != ST_ACTIVE) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A write colliding with apply stages the new value and keeps it pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Prescale      <= PRESCALE_WIDTH'(PRESCALE_RST);
            PAR_EN        <= 1'b0;
            PAR_TYP       <= 1'b0;
            pend_prescale <= PRESCALE_WIDTH'(PRESCALE_RST);
            pend_par_en   <= 1'b0;
            pend_par_typ  <= 1'b0;
            cfg_pending   <= 1'b0;
        end else begin
            if (apply_now) begin
                Prescale <= pend_prescale;
                PAR_EN   <= pend_par_en;
                PAR_TYP  <= pend_par_typ;
            end
            if (cfg_wr) begin
                pend_prescale <= cfg_prescale;
                pend_par_en   <= cfg_par_en;
                pend_par_typ  <= cfg_par_typ;
                cfg_pending   <= 1'b1;
            end else if (apply_now) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    rx_ctrl_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_req),
        .push_data (rx_p_data),
        .pop       (out_ready),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign drop      = push_req && fifo_full && !(out_ready && !fifo_empty);

    always_ff @(posedge CLK) begin
        if (RST)          overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

`ifdef UART_RX_CTRL_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_err_cnt <= 8'd0;
        end else if (ovr_clr) begin
            frame_err_cnt <= 8'd0;
        end else if (busy && !rx_data_valid && timeout_hit && frame_err_cnt != 8'hFF) begin
            frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default parameters).
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [4:0] cfg_prescale = 5'd8;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic       cfg_rx_en = 1'b0;
    logic       RX_IN = 1'b0;
    logic       rx_line;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] rx_p_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       overrun;
    logic       cfg_pending;
    logic       busy;
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] frame_err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .cfg_wr        (cfg_wr),
        .cfg_prescale  (cfg_prescale),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_typ   (cfg_par_typ),
        .cfg_rx_en     (cfg_rx_en),
        .RX_IN         (RX_IN),
        .rx_line       (rx_line),
        .Prescale      (Prescale),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .rx_p_data     (rx_p_data),
        .rx_data_valid (rx_data_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ovr_clr       (ovr_clr),
        .overrun       (overrun),
`ifdef UART_RX_CTRL_ERR_CNT_EN
        .frame_err_cnt (frame_err_cnt),
`endif
        .cfg_pending   (cfg_pending),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; cfg_rx_en = 1'b0; RX_IN = 1'b0;
        tick(2);
        RST = 1'b0;
        #1;
        checks++; if (rx_line !== 1'b1) begin errors++; $display("FAIL reset_rx_line got=%0b exp=1", rx_line); end
        checks++; if (Prescale !== 5'd8) begin errors++; $display("FAIL reset_prescale got=%0d exp=8", Prescale); end
        checks++; if ({PAR_EN, PAR_TYP} !== 2'b00) begin errors++; $display("FAIL reset_par got=%0b exp=00", {PAR_EN, PAR_TYP}); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%0h exp=00", out_data); end
        checks++; if ({overrun, cfg_pending} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%0b exp=00", {overrun, cfg_pending}); end
`ifdef UART_RX_CTRL_ERR_CNT_EN
        checks++; if (frame_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", frame_err_cnt); end
`endif
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_disabled_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_frame;
        RX_IN = 1'b1; cfg_rx_en = 1'b1;
        tick(1);
        RX_IN = 1'b0;
        #1;
        checks++; if (rx_line !== 1'b0) begin errors++; $display("FAIL frame_rx_line_pass got=%0b exp=0", rx_line); end
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got=%0b exp=1", busy); end
        RX_IN = 1'b1;
        tick(4);
        rx_p_data = 8'hA5; rx_data_valid = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_valid_early got=%0b exp=0", out_valid); end
        tick(1);
        rx_data_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL frame_out_data got=%0h exp=a5", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_drop got=%0b exp=0", busy); end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_pop got=%0b exp=0", out_valid); end
    endtask

    task automatic test_cfg_midframe;
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        cfg_prescale = 5'd31; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_wr = 1'b1;
        tick(1);
        cfg_prescale = 5'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL mid_pending got=%0b exp=1", cfg_pending); end
        checks++; if (Prescale !== 5'd8) begin errors++; $display("FAIL mid_prescale_hold got=%0d exp=8", Prescale); end
        tick(5);
        checks++; if (Prescale !== 5'd8 || busy !== 1'b1) begin errors++; $display("FAIL mid_active_hold got=%0d/%0b exp=8/1", Prescale, busy); end
        rx_p_data = 8'h3C; rx_data_valid = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
        checks++; if (Prescale !== 5'd8) begin errors++; $display("FAIL mid_idle_prescale got=%0d exp=8", Prescale); end
        tick(2);
        checks++; if (Prescale !== 5'd16) begin errors++; $display("FAIL mid_applied_prescale got=%0d exp=16", Prescale); end
        checks++; if ({PAR_EN, PAR_TYP, cfg_pending} !== 3'b110) begin errors++; $display("FAIL mid_applied_par got=%0b exp=110", {PAR_EN, PAR_TYP, cfg_pending}); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL mid_data got=%0h exp=3c", out_data); end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic test_cfg_collision;
        cfg_prescale = 5'd24; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        tick(1);
        cfg_prescale = 5'd8; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (Prescale !== 5'd24 || PAR_EN !== 1'b0) begin errors++; $display("FAIL coll_old_applied got=%0d/%0b exp=24/0", Prescale, PAR_EN); end
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coll_still_pending got=%0b exp=1", cfg_pending); end
        tick(2);
        checks++; if (Prescale !== 5'd8 || cfg_pending !== 1'b0) begin errors++; $display("FAIL coll_new_applied got=%0d/%0b exp=8/0", Prescale, cfg_pending); end
    endtask

    task automatic test_overrun;
        logic [7:0] vals [5];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            rx_p_data = vals[i]; rx_data_valid = 1'b1;
            if (i == 4) begin
                #1;
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before_drop got=%0b exp=0", overrun); end
            end
            tick(1);
        end
        rx_data_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin errors++; $display("FAIL ovr_pop%0d got=%0b/%0h exp=1/%0h", i, out_valid, out_data, vals[i]); end
            out_ready = 1'b1;
            tick(1);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got=%0b exp=0", out_valid); end
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 4; i++) begin
            rx_p_data = 8'hA0 + 8'(i); rx_data_valid = 1'b1;
            tick(1);
        end
        rx_p_data = 8'hA4; out_ready = 1'b1;
        tick(1);
        rx_data_valid = 1'b0; out_ready = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fpp_no_overrun got=%0b exp=0", overrun); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL fpp_pop%0d got=%0b/%0h exp=1/%0h", i, out_valid, out_data, 8'hA0 + 8'(i)); end
            out_ready = 1'b1;
            tick(1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained got=%0b exp=0", out_valid); end
        tick(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL empty_pop got=%0b/%0h exp=0/00", out_valid, out_data); end
        for (int i = 0; i < 4; i++) begin
            rx_p_data = 8'hB0 + 8'(i); rx_data_valid = 1'b1;
            tick(1);
        end
        rx_p_data = 8'hB4; ovr_clr = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got=%0b exp=1", overrun); end
        tick(1);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_after got=%0b exp=0", overrun); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL coll_pop%0d got=%0h exp=%0h", i, out_data, 8'hB0 + 8'(i)); end
            out_ready = 1'b1;
            tick(1);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_disabled;
        cfg_rx_en = 1'b0;
        tick(1);
        RX_IN = 1'b0;
        #1;
        checks++; if (rx_line !== 1'b1) begin errors++; $display("FAIL dis_rx_line got=%0b exp=1", rx_line); end
        rx_p_data = 8'h77; rx_data_valid = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dis_push_ignored got=%0b exp=0", out_valid); end
        cfg_prescale = 5'd16; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL dis_pending got=%0b exp=1", cfg_pending); end
        tick(1);
        checks++; if (Prescale !== 5'd16 || cfg_pending !== 1'b0) begin errors++; $display("FAIL dis_apply got=%0d/%0b exp=16/0", Prescale, cfg_pending); end
        cfg_prescale = 5'd8; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        tick(1);
        checks++; if (Prescale !== 5'd8) begin errors++; $display("FAIL dis_restore got=%0d exp=8", Prescale); end
        RX_IN = 1'b1; cfg_rx_en = 1'b1;
        tick(1);
    endtask

    task automatic test_abandon;
        RX_IN = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abn_busy got=%0b exp=1", busy); end
        cfg_rx_en = 1'b0;
        #1;
        checks++; if (rx_line !== 1'b1) begin errors++; $display("FAIL abn_line_high got=%0b exp=1", rx_line); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abn_disabled got=%0b exp=0", busy); end
        RX_IN = 1'b1; cfg_rx_en = 1'b1;
        tick(1);
    endtask

    task automatic test_timeout;
        RX_IN = 1'b0;
        tick(1);
        RX_IN = 1'b1;
        tick(176);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_still_active got=%0b exp=1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got=%0b exp=0", busy); end
`ifdef UART_RX_CTRL_ERR_CNT_EN
        checks++; if (frame_err_cnt !== 8'd1) begin errors++; $display("FAIL tmo_err_cnt got=%0d exp=1", frame_err_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame();
        test_cfg_midframe();
        test_cfg_collision();
        test_overrun();
        test_full_push_pop();
        test_disabled();
        test_abandon();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
